start_watchdog: RTL and testbench
=================================

START_WATCHDOG -- requirements
Module: start_watchdog

Interface
REQ-001 SHALL have parameter WINDOW, default 20: number of clock cycles per observation window (legal 1..255).
REQ-002 SHALL have parameter CNT_W, default 8: width of the hit counter and first-hit latency outputs.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port arm  input  1  single-cycle request to open a new observation window.
REQ-006 SHALL have port start  input  1  monitored signal, sampled on posedge clk.
REQ-007 SHALL have port busy  output  1  high while a window is open.
REQ-008 SHALL have port first_seen  output  1  one-cycle pulse on the first sampled start=1 in a window.
REQ-009 SHALL have port first_lat  output  CNT_W  cycle index (1-based) of the first hit; held until the next arm.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a window closes.
REQ-011 SHALL have port pass  output  1  level; 1 if the last closed window had hits>0; held until the next arm.
REQ-012 SHALL have port fail  output  1  level; 1 if the last closed window had zero hits; held until the next arm.
REQ-013 SHALL have port hit_cnt  output  CNT_W  number of window cycles with start=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, PASS, FAIL.
REQ-015 SHALL go IDLE/PASS/FAIL -> WAIT on arm=1, clearing the cycle counter, hit_cnt, first_lat, pass and fail in that same edge.
REQ-016 SHALL NOT sample start in the arm cycle; sample 1 is the first posedge after arm.
REQ-017 SHALL, in WAIT, increment the cycle counter each edge and increment hit_cnt when start=1.
REQ-018 SHALL assert first_seen and load first_lat with the sample index on the first start=1 sample of the window only.
REQ-019 SHALL leave WAIT after exactly WINDOW samples, with the final sample included in hit_cnt.
REQ-020 SHALL, on that final sample, pulse done and enter PASS (pass=1) if hits>0 including the final sample, else FAIL (fail=1).
REQ-021 SHALL have done/pass/fail visible in the cycle after the final sample edge, giving latency arm -> done = WINDOW+1 cycles.
REQ-022 SHALL ignore arm while in WAIT; the window is not restarted.
REQ-023 SHALL honour arm in the same cycle PASS/FAIL is entered from WAIT only on the following cycle; the arm is dropped because WAIT is still active.
REQ-024 SHALL saturate hit_cnt at 2^CNT_W-1.
REQ-025 SHALL drive busy=1 exactly in WAIT.
REQ-026 SHALL never assert pass and fail simultaneously.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-window, immediately force state IDLE with all outputs and counters 0.
REQ-028 SHALL require a fresh arm after rst_n deasserts; no window resumes.

Configuration
REQ-029 SHALL use macro START_WD_HITCNT_EN: when defined, hit_cnt counts per REQ-017/REQ-024.
REQ-030 SHALL, when START_WD_HITCNT_EN is undefined, omit the hit counter register and tie hit_cnt to 0.
REQ-031 SHALL, when START_WD_HITCNT_EN is undefined, derive pass/fail from a 1-bit "any hit" flag with identical timing.

Verification
REQ-032 SHALL cover: WINDOW=20; arm at cycle 0, start=1 from sample 10 onward -> first_seen at sample 10, first_lat=10, hit_cnt=11, done at cycle 21, pass=1.
REQ-033 SHALL cover: arm, start held 0 for 20 samples -> done at cycle 21, fail=1, hit_cnt=0, first_seen never pulses.
REQ-034 SHALL cover: start=1 only on sample 20 -> pass=1, first_lat=20, hit_cnt=1; start=1 only in the arm cycle -> fail=1.
REQ-035 SHALL cover: second arm at sample 5 -> ignored, done still at cycle 21; arm in PASS -> busy=1 next cycle, pass cleared.
REQ-036 SHALL cover: rst_n=0 at sample 12 of a window with hits -> all outputs 0 immediately, no done pulse, IDLE after release.
REQ-037 SHALL cover: CNT_W=3, start=1 for all 20 samples -> hit_cnt saturates at 7, pass=1; rerun without START_WD_HITCNT_EN -> hit_cnt=0, pass=1.

Source files
------------

// File: rtl/start_watchdog_if.sv
`timescale 1ns/1ps
// Purpose : handshake/status bundle between a start_watchdog and its controller.
// Latency : n/a (wires only).
// Backpressure: none; arm is a single-cycle request, all status outputs are levels or pulses.
//
// Signals
//   arm        controller -> watchdog  open a new observation window
//   start      controller -> watchdog  monitored signal
//   busy       watchdog -> controller  window open
//   first_seen watchdog -> controller  pulse on first hit of a window
//   first_lat  watchdog -> controller  1-based sample index of first hit
//   done       watchdog -> controller  pulse when the window closes
//   pass/fail  watchdog -> controller  verdict of last closed window
//   hit_cnt    watchdog -> controller  number of window samples with start=1
interface start_watchdog_if #(
  parameter int CNT_W = 8
);
  logic             arm;
  logic             start;
  logic             busy;
  logic             first_seen;
  logic [CNT_W-1:0] first_lat;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output arm, start,
    input  busy, first_seen, first_lat, done, pass, fail, hit_cnt
  );

  modport slave (
    input  arm, start,
    output busy, first_seen, first_lat, done, pass, fail, hit_cnt
  );
endinterface

// File: rtl/start_watchdog.sv
`timescale 1ns/1ps
// Purpose : watches 'start' for WINDOW cycles after an arm and reports whether it was ever seen.
// Latency : arm -> done is WINDOW+1 cycles; first_seen one cycle after the hitting sample.
// Backpressure: none; arm is ignored while a window is open.
//
// Ports: clk, rst_n (async, active-low), wd (start_watchdog_if.slave: arm/start in,
//        busy/first_seen/first_lat/done/pass/fail/hit_cnt out).
// Build option: START_WD_HITCNT_EN -- when defined a saturating hit counter drives hit_cnt;
//        otherwise hit_cnt is tied to 0 and pass/fail come from a 1-bit any-hit flag.
module start_watchdog #(
  parameter int WINDOW = 20,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  start_watchdog_if.slave wd
);

  localparam int                 CYC_W   = 8;
  localparam logic [CYC_W-1:0]   WIN_C   = CYC_W'(WINDOW);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] samp_idx;
  logic             busy_q, busy_d;
  logic             first_seen_q, first_seen_d;
  logic [CNT_W-1:0] first_lat_q, first_lat_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             seen;

`ifdef START_WD_HITCNT_EN
  logic [CNT_W-1:0] hit_q, hit_d;
  // A saturating counter never returns to zero, so nonzero means "already hit".
  assign seen = (hit_q != '0);
`else
  logic any_q, any_d;
  assign seen = any_q;
`endif

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    first_seen_d = 1'b0;
    first_lat_d  = first_lat_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_d       = fail_q;
`ifdef START_WD_HITCNT_EN
    hit_d        = hit_q;
`else
    any_d        = any_q;
`endif
    // cyc_q holds samples already taken, so this edge takes sample cyc_q+1.
    samp_idx     = cyc_q + 1'b1;

    case (state_q)
      WAIT: begin
        cyc_d = samp_idx;
        if (wd.start) begin
          if (!seen) begin
            first_seen_d = 1'b1;
            first_lat_d  = CNT_W'(samp_idx);
          end
`ifdef START_WD_HITCNT_EN
          if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
`else
          any_d = 1'b1;
`endif
        end
        // Verdict includes the final sample itself, hence the OR with start.
        if (samp_idx == WIN_C) begin
          done_d = 1'b1;
          if (seen || wd.start) begin
            state_d = PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end
        end
      end
      default: begin
        // IDLE, PASS and FAIL all accept a new arm; arm during WAIT falls through above.
        if (wd.arm) begin
          state_d     = WAIT;
          cyc_d       = '0;
          first_lat_d = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
`ifdef START_WD_HITCNT_EN
          hit_d       = '0;
`else
          any_d       = 1'b0;
`endif
        end
      end
    endcase

    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      busy_q       <= 1'b0;
      first_seen_q <= 1'b0;
      first_lat_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
`ifdef START_WD_HITCNT_EN
      hit_q        <= '0;
`else
      any_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      busy_q       <= busy_d;
      first_seen_q <= first_seen_d;
      first_lat_q  <= first_lat_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
`ifdef START_WD_HITCNT_EN
      hit_q        <= hit_d;
`else
      any_q        <= any_d;
`endif
    end
  end

  assign wd.busy       = busy_q;
  assign wd.first_seen = first_seen_q;
  assign wd.first_lat  = first_lat_q;
  assign wd.done       = done_q;
  assign wd.pass       = pass_q;
  assign wd.fail       = fail_q;
`ifdef START_WD_HITCNT_EN
  assign wd.hit_cnt    = hit_q;
`else
  assign wd.hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_start_watchdog.sv
`timescale 1ns/1ps
module tb_start_watchdog;
  localparam int W = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  start_watchdog_if #(.CNT_W(8)) wd ();
  start_watchdog_if #(.CNT_W(3)) wd3 ();

  start_watchdog #(.WINDOW(W), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .wd(wd));
  start_watchdog #(.WINDOW(W), .CNT_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .wd(wd3));

  int checks = 0;
  int passed = 0;

  // Observations of one window on the 8-bit instance (cycle 0 = arm cycle).
  int          o_fs_cnt, o_fs_cyc, o_done_cnt, o_done_cyc, o_pf_both;
  logic        o_pass, o_fail;
  logic [7:0]  o_lat, o_hits;
  logic [31:0] o_busy;
  logic        o_c1_pass, o_c1_fail;
  logic [7:0]  o_c1_lat, o_c1_hits;

  // Expected values from the window rules: samples 1..W count, the arm cycle does not.
  int   e_hits, e_first;
  logic e_pass;

  task automatic model(input logic [W:0] pat, input int cw);
    int maxv;
    maxv = (1 << cw) - 1;
    e_hits = 0;
    e_first = 0;
    for (int k = 1; k <= W; k++) begin
      if (pat[k]) begin
        if (e_first == 0) e_first = k;
        e_hits++;
      end
    end
    e_pass = (e_hits > 0);
    if (e_hits > maxv) e_hits = maxv;
`ifndef START_WD_HITCNT_EN
    e_hits = 0;
`endif
  endtask

  // Arms in the current cycle, then drives pat[c] in cycle c and records outputs for cycles 1..24.
  // arm2 >= 1 asserts arm again in that cycle.
  task automatic run_window(input logic [W:0] pat, input int arm2);
    wd.arm = 1'b1;
    wd.start = pat[0];
    @(posedge clk); #1;
    o_fs_cnt = 0; o_fs_cyc = -1; o_done_cnt = 0; o_done_cyc = -1; o_pf_both = 0;
    o_pass = 1'bx; o_fail = 1'bx; o_lat = 'x; o_hits = 'x; o_busy = '0;
    for (int c = 1; c <= 24; c++) begin
      wd.arm = (c == arm2);
      wd.start = (c <= W) ? pat[c] : 1'b0;
      o_busy[c] = wd.busy;
      if (c == 1) begin
        o_c1_pass = wd.pass; o_c1_fail = wd.fail; o_c1_lat = wd.first_lat; o_c1_hits = wd.hit_cnt;
      end
      if (wd.first_seen) begin
        o_fs_cnt++;
        if (o_fs_cyc < 0) o_fs_cyc = c;
      end
      if (wd.done) begin
        o_done_cnt++;
        o_done_cyc = c;
        o_pass = wd.pass; o_fail = wd.fail; o_lat = wd.first_lat; o_hits = wd.hit_cnt;
      end
      if (wd.pass && wd.fail) o_pf_both++;
      @(posedge clk); #1;
    end
    wd.arm = 1'b0;
    wd.start = 1'b0;
  endtask

  localparam logic [31:0] EXP_BUSY = 32'h001F_FFFE; // cycles 1..20

  task automatic test_reset;
    wd.arm = 0; wd.start = 0; wd3.arm = 0; wd3.start = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wd.busy, wd.first_seen, wd.done, wd.pass, wd.fail} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {wd.busy, wd.first_seen, wd.done, wd.pass, wd.fail});
    else passed++;
    checks++;
    if ({wd.first_lat, wd.hit_cnt} !== 16'h0)
      $display("FAIL reset_counts: got lat=%0d hits=%0d want 0/0", wd.first_lat, wd.hit_cnt);
    else passed++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wd.busy, wd.done, wd.pass, wd.fail} !== 4'b0)
      $display("FAIL reset_idle_after_release: got %b want 0000", {wd.busy, wd.done, wd.pass, wd.fail});
    else passed++;
  endtask

  task automatic test_late_start;
    logic [W:0] pat;
    pat = '0;
    for (int k = 10; k <= W; k++) pat[k] = 1'b1;
    model(pat, 8);
    run_window(pat, -1);
    checks++;
    if (o_fs_cyc !== 11 || o_fs_cnt !== 1)
      $display("FAIL late_first_seen: got cyc=%0d cnt=%0d want cyc=11 cnt=1", o_fs_cyc, o_fs_cnt);
    else passed++;
    checks++;
    if (o_lat !== 8'd10) $display("FAIL late_first_lat: got %0d want 10", o_lat);
    else passed++;
    checks++;
    if (o_hits !== 8'(e_hits)) $display("FAIL late_hit_cnt: got %0d want %0d", o_hits, e_hits);
    else passed++;
    checks++;
    if (o_done_cyc !== 21 || o_done_cnt !== 1 || o_pass !== 1'b1 || o_fail !== 1'b0)
      $display("FAIL late_done: got cyc=%0d n=%0d pass=%b fail=%b want 21/1/1/0", o_done_cyc, o_done_cnt, o_pass, o_fail);
    else passed++;
    checks++;
    if (o_busy !== EXP_BUSY) $display("FAIL late_busy: got %h want %h", o_busy, EXP_BUSY);
    else passed++;
  endtask

  task automatic test_no_hit;
    logic [W:0] pat;
    pat = '0;
    run_window(pat, -1);
    checks++;
    if (o_done_cyc !== 21 || o_pass !== 1'b0 || o_fail !== 1'b1)
      $display("FAIL nohit_done: got cyc=%0d pass=%b fail=%b want 21/0/1", o_done_cyc, o_pass, o_fail);
    else passed++;
    checks++;
    if (o_fs_cnt !== 0 || o_hits !== 8'd0)
      $display("FAIL nohit_counts: got fs=%0d hits=%0d want 0/0", o_fs_cnt, o_hits);
    else passed++;
  endtask

  task automatic test_boundary_samples;
    logic [W:0] pat;
    pat = '0;
    pat[W] = 1'b1;
    model(pat, 8);
    run_window(pat, -1);
    checks++;
    if (o_pass !== 1'b1 || o_lat !== 8'd20 || o_hits !== 8'(e_hits) || o_fs_cyc !== 21)
      $display("FAIL last_sample: got pass=%b lat=%0d hits=%0d fs=%0d want 1/20/%0d/21", o_pass, o_lat, o_hits, o_fs_cyc, e_hits);
    else passed++;
    pat = '0;
    pat[0] = 1'b1;
    run_window(pat, -1);
    checks++;
    if (o_fail !== 1'b1 || o_pass !== 1'b0 || o_fs_cnt !== 0)
      $display("FAIL arm_cycle_only: got fail=%b pass=%b fs=%0d want 1/0/0", o_fail, o_pass, o_fs_cnt);
    else passed++;
  endtask

  task automatic test_rearm;
    logic [W:0] pat;
    pat = '0;
    pat[3] = 1'b1;
    run_window(pat, 5);
    checks++;
    if (o_done_cyc !== 21 || o_done_cnt !== 1 || o_busy !== EXP_BUSY)
      $display("FAIL rearm_in_wait: got done=%0d n=%0d busy=%h want 21/1/%h", o_done_cyc, o_done_cnt, o_busy, EXP_BUSY);
    else passed++;
    // Arm in the final-sample cycle is dropped: no new window afterwards.
    run_window(pat, 20);
    checks++;
    if (o_busy !== EXP_BUSY || o_done_cnt !== 1)
      $display("FAIL rearm_final_cycle: got busy=%h n=%0d want %h/1", o_busy, o_done_cnt, EXP_BUSY);
    else passed++;
    // Previous window ended in PASS; arming now must clear the verdict and open a window.
    pat = '0;
    run_window(pat, -1);
    checks++;
    if (o_busy[1] !== 1'b1 || o_c1_pass !== 1'b0 || o_c1_fail !== 1'b0 || o_c1_lat !== 8'd0 || o_c1_hits !== 8'd0)
      $display("FAIL arm_in_pass: got busy=%b pass=%b fail=%b lat=%0d hits=%0d want 1/0/0/0/0",
               o_busy[1], o_c1_pass, o_c1_fail, o_c1_lat, o_c1_hits);
    else passed++;
    checks++;
    if (o_fail !== 1'b1) $display("FAIL arm_in_pass_verdict: got fail=%b want 1", o_fail);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int dones, busies;
    wd.arm = 1'b1; wd.start = 1'b0;
    @(posedge clk); #1;
    wd.arm = 1'b0;
    for (int c = 1; c < 12; c++) begin
      wd.start = (c >= 3);
      @(posedge clk); #1;
    end
    checks++;
    if (wd.first_lat !== 8'd3 || wd.busy !== 1'b1)
      $display("FAIL midreset_pre: got lat=%0d busy=%b want 3/1", wd.first_lat, wd.busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wd.busy, wd.first_seen, wd.done, wd.pass, wd.fail} !== 5'b0 || wd.first_lat !== 8'd0)
      $display("FAIL midreset_async: got flags=%b lat=%0d want 00000/0",
               {wd.busy, wd.first_seen, wd.done, wd.pass, wd.fail}, wd.first_lat);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0; busies = 0;
    for (int c = 0; c < 25; c++) begin
      if (wd.done) dones++;
      if (wd.busy) busies++;
      @(posedge clk); #1;
    end
    wd.start = 1'b0;
    checks++;
    if (dones !== 0 || busies !== 0)
      $display("FAIL midreset_no_resume: got dones=%0d busy_cycles=%0d want 0/0", dones, busies);
    else passed++;
  endtask

  task automatic test_random;
    logic [W:0] pat;
    int arm2, efs;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k <= W; k++) pat[k] = ($urandom_range(0, 5) == 0);
      if (it == 0) pat = '0;
      arm2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : -1;
      model(pat, 8);
      run_window(pat, arm2);
      efs = e_pass ? e_first + 1 : -1;
      checks++;
      if (o_done_cyc !== W + 1 || o_done_cnt !== 1 || o_busy !== EXP_BUSY)
        $display("FAIL rand%0d_timing: got done=%0d n=%0d busy=%h", it, o_done_cyc, o_done_cnt, o_busy);
      else passed++;
      checks++;
      if (o_pass !== e_pass || o_fail !== !e_pass || o_pf_both !== 0)
        $display("FAIL rand%0d_verdict: got pass=%b fail=%b both=%0d want pass=%b", it, o_pass, o_fail, o_pf_both, e_pass);
      else passed++;
      checks++;
      if (o_lat !== 8'(e_first) || o_hits !== 8'(e_hits) || o_fs_cyc !== efs || o_fs_cnt !== (e_pass ? 1 : 0))
        $display("FAIL rand%0d_counts: got lat=%0d hits=%0d fs=%0d/%0d want %0d/%0d/%0d",
                 it, o_lat, o_hits, o_fs_cyc, o_fs_cnt, e_first, e_hits, efs);
      else passed++;
    end
  endtask

  task automatic test_saturation;
    logic [W:0] pat;
    logic [2:0] h, l;
    logic p, f;
    int dc;
    pat = '1;
    pat[0] = 1'b0;
    model(pat, 3);
    dc = -1; h = 'x; l = 'x; p = 1'bx; f = 1'bx;
    wd3.arm = 1'b1; wd3.start = 1'b0;
    @(posedge clk); #1;
    wd3.arm = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      wd3.start = (c <= W);
      if (wd3.done) begin
        dc = c; h = wd3.hit_cnt; l = wd3.first_lat; p = wd3.pass; f = wd3.fail;
      end
      @(posedge clk); #1;
    end
    wd3.start = 1'b0;
    checks++;
    if (dc !== 21 || p !== 1'b1 || f !== 1'b0 || l !== 3'd1)
      $display("FAIL sat_verdict: got done=%0d pass=%b fail=%b lat=%0d want 21/1/0/1", dc, p, f, l);
    else passed++;
    checks++;
    if (h !== 3'(e_hits)) $display("FAIL sat_hit_cnt: got %0d want %0d", h, e_hits);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_late_start();
    test_no_hit();
    test_boundary_samples();
    test_rearm();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
